// File: rtl/boton_debounce.sv
// rtl/boton_debounce.sv - per-channel synchronised push-button debouncer
// Outputs debounced levels, press/release pulses and a clearable sticky press flag.
module boton_debounce #(
  parameter int N_CH       = 2,
  parameter int DEB_CYCLES = 500000,
  parameter int ACTIVE_LOW = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] data_btn,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] event_sticky,
  input  logic [N_CH-1:0] clr_event
);

  localparam int               CNT_W    = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [N_CH-1:0]  SYNC_RST = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};

  logic [N_CH-1:0]  sync1_q, sync1_d;
  logic [N_CH-1:0]  sync2_q, sync2_d;
  logic [N_CH-1:0]  level;
  logic [N_CH-1:0]  stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q [N_CH];
  logic [CNT_W-1:0] cnt_d [N_CH];
  logic [N_CH-1:0]  press_q, press_d;
  logic [N_CH-1:0]  release_q, release_d;
  logic [N_CH-1:0]  sticky_q, sticky_d;

  // Normalised so that 1 always means pressed downstream of the synchroniser.
  assign level = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  always_comb begin
    sync1_d  = btn_in;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    for (int i = 0; i < N_CH; i++) begin
      cnt_d[i] = '0;
      if (level[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          stable_d[i] = level[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = stable_d & ~stable_q;
    release_d = ~stable_d & stable_q;
    // A press in the same cycle as a clear keeps the flag set.
    sticky_d  = press_q | (sticky_q & ~clr_event);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q   <= SYNC_RST;
      sync2_q   <= SYNC_RST;
      stable_q  <= '0;
      press_q   <= '0;
      release_q <= '0;
      sticky_q  <= '0;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      stable_q  <= stable_d;
      press_q   <= press_d;
      release_q <= release_d;
      sticky_q  <= sticky_d;
      for (int i = 0; i < N_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign data_btn      = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign event_sticky  = sticky_q;

endmodule

// File: tb/tb_boton_debounce.sv
// tb/tb_boton_debounce.sv - scoreboard bench for boton_debounce
// Two instances: active-high and active-low pins, DEB_CYCLES=4.
module tb_boton_debounce;
  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  logic       clk = 1'b0;
  logic       rst0_n, rst1_n;
  logic [1:0] btn0, btn1, clr0, clr1;
  logic [1:0] data0, press0, rel0, stk0;
  logic [1:0] data1, press1, rel1, stk1;

  int cyc = 0;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    int cyc;
    int who;
  } ev_t;
  ev_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  boton_debounce #(.N_CH(2), .DEB_CYCLES(DEB), .ACTIVE_LOW(0)) dut0 (
    .clk(clk), .rst_n(rst0_n), .btn_in(btn0), .data_btn(data0),
    .press_pulse(press0), .release_pulse(rel0), .event_sticky(stk0), .clr_event(clr0)
  );

  boton_debounce #(.N_CH(2), .DEB_CYCLES(DEB), .ACTIVE_LOW(1)) dut1 (
    .clk(clk), .rst_n(rst1_n), .btn_in(btn1), .data_btn(data1),
    .press_pulse(press1), .release_pulse(rel1), .event_sticky(stk1), .clr_event(clr1)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  // who = inst*4 + kind*2 + ch, kind 1 = press, 0 = release
  task automatic expect_ev(input int inst, input int ch, input int kind);
    ev_t e;
    e.cyc = cyc + LAT;
    e.who = inst * 4 + kind * 2 + ch;
    exp_q.push_back(e);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [7:0] pulses;
    ev_t e;
    pulses = {press1, rel1, press0, rel0};
    for (int w = 0; w < 8; w++) begin
      if (pulses[w]) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pulse", w, -1);
        end else begin
          e = exp_q.pop_front();
          check("pulse_cycle", cyc, e.cyc);
          check("pulse_who", w, e.who);
        end
      end
    end
  end

  initial begin
    rst0_n = 1'b0; rst1_n = 1'b0;
    btn0 = 2'b00; btn1 = 2'b11; clr0 = 2'b00; clr1 = 2'b00;
    step(3);
    check("rst_data0", data0, 0);
    check("rst_sticky0", stk0, 0);
    check("rst_data1", data1, 0);
    check("rst_pulses", {press0, rel0, press1, rel1}, 0);
    rst0_n = 1'b1; rst1_n = 1'b1;
    step(20);
    check("idle_data0", data0, 0);
    check("idle_sticky0", stk0, 0);
    check("idle_data1_al", data1, 0);
    check("idle_sticky1_al", stk1, 0);

    btn0 = 2'b01; expect_ev(0, 0, 1);
    step(LAT - 1);
    check("pre_accept_data0", data0, 0);
    step(1);
    check("accept_data0", data0, 2'b01);
    check("sticky_not_yet", stk0, 0);
    step(1);
    check("sticky_set0", stk0, 2'b01);
    check("press_one_cycle", press0, 0);
    step(2);

    btn0 = 2'b00; expect_ev(0, 0, 0);
    step(LAT + 2);
    check("released_data0", data0, 0);

    repeat (4) begin
      btn0[0] = 1'b1; step(3);
      btn0[0] = 1'b0; step(1);
    end
    check("bounce_data0", data0, 0);
    btn0[0] = 1'b1; expect_ev(0, 0, 1);
    step(LAT + 2);
    check("bounce_accept", data0, 2'b01);

    btn0[1] = 1'b1; expect_ev(0, 1, 1);
    step(LAT + 2);
    check("ch1_press_data", data0, 2'b11);
    check("ch1_sticky", stk0, 2'b11);
    btn0[1] = 1'b0; expect_ev(0, 1, 0);
    step(LAT + 2);
    check("ch1_release_data", data0, 2'b01);
    check("ch1_sticky_kept", stk0[1], 1);

    clr0 = 2'b01; step(1); clr0 = 2'b00;
    check("lone_clear", stk0, 2'b10);

    btn0[0] = 1'b0; expect_ev(0, 0, 0);
    step(LAT + 2);
    clr0 = 2'b01; step(1); clr0 = 2'b00;
    check("clear_zero_noop", stk0, 2'b10);
    btn0[0] = 1'b1; expect_ev(0, 0, 1);
    step(LAT);
    check("press_now", press0, 2'b01);
    clr0 = 2'b01; step(1); clr0 = 2'b00;
    check("set_wins", stk0[0], 1);
    step(1);
    clr0 = 2'b01; step(1); clr0 = 2'b00;
    check("clear_after_set", stk0[0], 0);

    btn1[0] = 1'b0; expect_ev(1, 0, 1);
    step(LAT + 2);
    check("al_press_data", data1, 2'b01);
    check("al_sticky", stk1, 2'b01);
    btn1[1] = 1'b0;
    step(3);
    rst1_n = 1'b0;
    #1;
    check("midrst_outputs", {data1, press1, rel1, stk1}, 0);
    step(2);
    rst1_n = 1'b1; expect_ev(1, 0, 1); expect_ev(1, 1, 1);
    step(LAT - 1);
    check("post_rst_quiet", data1, 0);
    step(1);
    check("post_rst_press", data1, 2'b11);
    step(3);

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
